// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting between register-file reads and writeback.
// One shared hi/lo register pair serves as the shift-add product or the restoring
// remainder/quotient. Division by zero and signed overflow skip the iteration entirely.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    input  logic                  kill,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] rd_out
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] LAST_IT  = CW'(DATA_WIDTH - 1);

    // Everything about the accepted operation that is needed after accept
    typedef struct packed {
        logic [2:0]            funct3;
        logic [ADDR_WIDTH-1:0] rd;
        logic                  neg_p;    // flip product / quotient
        logic                  neg_r;    // flip remainder (follows dividend)
        logic                  special;  // lo_q already holds the final answer
    } op_t;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    op_t                   op_q, op_d;
    logic [DW-1:0]         mcand_q;      // multiplicand or divisor magnitude
    logic [DW-1:0]         hi_q, lo_q;
    logic [DW-1:0]         result_q;
    logic [ADDR_WIDTH-1:0] rd_out_q;

    logic          is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [DW-1:0] a_mag, b_mag, spec_val;

    // Accept-time decode: signedness, magnitudes and special-case detection
    assign is_div   = funct3[2];
    assign sgn_a    = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign sgn_b    = is_div ? ~funct3[0] : ~funct3[1];
    assign neg_a    = sgn_a & op_a[DW-1];
    assign neg_b    = sgn_b & op_b[DW-1];
    assign a_mag    = neg_a ? -op_a : op_a;
    assign b_mag    = neg_b ? -op_b : op_b;
    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = is_div && !funct3[0] && (op_a == MOST_NEG) && (op_b == ALL_ONES);
    assign spec_val = div_zero ? (funct3[1] ? op_a : ALL_ONES)
                               : (funct3[1] ? '0   : op_a);

    // Pack the accepted request
    always_comb begin
        op_d         = '0;
        op_d.funct3  = funct3;
        op_d.rd      = rd_in;
        op_d.neg_p   = neg_a ^ neg_b;
        op_d.neg_r   = neg_a;
        op_d.special = div_zero | div_ovf;
    end

    logic [DW:0]   sum, shifted, diff;
    logic [DW-1:0] hi_n, lo_n;

    // One iteration: shift-add multiply step or restoring divide step
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {hi_q, lo_q[DW-1]};
        diff    = shifted - {1'b0, mcand_q};
        hi_n    = sum[DW:1];
        lo_n    = {sum[0], lo_q[DW-1:1]};
        if (op_q.funct3[2]) begin
            if (!diff[DW]) begin
                hi_n = diff[DW-1:0];
                lo_n = {lo_q[DW-2:0], 1'b1};
            end else begin
                hi_n = shifted[DW-1:0];
                lo_n = {lo_q[DW-2:0], 1'b0};
            end
        end
    end

    logic [2*DW-1:0] prod_raw, prod;
    logic [DW-1:0]   quo, rem, fin_val;

    // Final sign correction and half/quotient/remainder selection
    always_comb begin
        prod_raw = {hi_q, lo_q};
        prod     = op_q.neg_p ? -prod_raw : prod_raw;
        quo      = op_q.neg_p ? -lo_q : lo_q;
        rem      = op_q.neg_r ? -hi_q : hi_q;
        if (op_q.special)
            fin_val = lo_q;
        else if (op_q.funct3[2])
            fin_val = op_q.funct3[1] ? rem : quo;
        else if (op_q.funct3[1:0] == 2'b00)
            fin_val = prod[DW-1:0];
        else
            fin_val = prod[2*DW-1:DW];
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FIN);
    assign result = done ? fin_val : result_q;
    assign rd_out = done ? op_q.rd : rd_out_q;

    // Control FSM and datapath registers
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !kill) begin
                        op_q    <= op_d;
                        mcand_q <= is_div ? b_mag : a_mag;
                        hi_q    <= '0;
                        lo_q    <= op_d.special ? spec_val : (is_div ? a_mag : b_mag);
                        cnt     <= '0;
                        state   <= op_d.special ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state <= S_IDLE;
                    end else begin
                        hi_q <= hi_n;
                        lo_q <= lo_n;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_IT)
                            state <= S_FIN;
                    end
                end
                S_FIN: begin
                    // done is already visible this cycle, so kill cannot retract it
                    result_q <= fin_val;
                    rd_out_q <= op_q.rd;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random operations against an arithmetic model.
module tb_muldiv_unit;
    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RES(RES), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .rd_in(rd_in), .kill(kill), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // RV32M semantics written with native arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f)
            3'd0: return a * b;
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op (call at a falling edge), then check latency, result, rd, strobe width
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        logic [31:0] exp;
        int lat, n;
        bit seen;
        exp  = ref_model(f, a, b);
        lat  = is_special(f, a, b) ? 1 : 33;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        n = 0; seen = 0;
        while (n < 40 && !seen) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                start = 1'b0;
                op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
                chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            end
            if (done) seen = 1;
        end
        chk({tag, " latency"}, seen ? 32'(n) : 32'd0, 32'(lat));
        chk({tag, " result"}, result, exp);
        chk({tag, " rd"}, {27'd0, rd_out}, {27'd0, rd});
        @(negedge CLK);
        chk({tag, " done width"}, {31'd0, done}, 32'd0);
        chk({tag, " idle"}, {31'd0, busy}, 32'd0);
        chk({tag, " hold"}, result, exp);
    endtask

    initial begin
        int dones, first;
        logic [2:0]  f;
        logic [31:0] a, b;

        #1 RES = 1'b0;
        #11;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd", {27'd0, rd_out}, 32'd0);
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd12, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, "rem");
        run_op(3'd5, 32'd7, 32'd2, 5'd6, "divu");
        run_op(3'd7, 32'd7, 32'd2, 5'd7, "remu");
        run_op(3'd4, 32'd5, 32'd0, 5'd8, "div0");
        run_op(3'd7, 32'd5, 32'd0, 5'd0, "remu0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "divovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "removf");

        // Second start during busy is dropped
        start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'd3; rd_in = 5'd9;
        dones = 0; first = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge CLK);
            start = (n == 5);
            if (n == 5) begin funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd20; end
            if (done) begin dones++; if (first == 0) first = n; end
        end
        start = 1'b0;
        chk("busy-start dones", 32'(dones), 32'd1);
        chk("busy-start latency", 32'(first), 32'd33);
        chk("busy-start result", result, 32'd21);
        chk("busy-start rd", {27'd0, rd_out}, 32'd9);

        // Kill mid-calculation, then restart immediately
        start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
        dones = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge CLK);
            start = 1'b0;
            kill = (n == 10);
            if (done) dones++;
        end
        chk("kill busy", {31'd0, busy}, 32'd0);
        chk("kill no done", 32'(dones), 32'd0);
        chk("kill result kept", result, 32'd21);
        chk("kill rd kept", {27'd0, rd_out}, 32'd9);
        run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 5'd17, "after kill");

        // Kill wins over start in IDLE
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2;
        @(negedge CLK);
        start = 1'b0; kill = 1'b0;
        chk("kill over start", {31'd0, busy}, 32'd0);
        @(negedge CLK);

        // Asynchronous reset mid-calculation
        start = 1'b1; funct3 = 3'd0; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd30;
        repeat (10) begin @(negedge CLK); start = 1'b0; end
        #2 RES = 1'b0;
        #1;
        chk("areset busy", {31'd0, busy}, 32'd0);
        chk("areset done", {31'd0, done}, 32'd0);
        chk("areset result", result, 32'd0);
        chk("areset rd", {27'd0, rd_out}, 32'd0);
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        run_op(3'd3, 32'd3, 32'd5, 5'd14, "mulhu post-reset");

        // Random operations, with divisor-zero / overflow / small operands mixed in
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(0, 3));
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 1000)); b = -32'($urandom_range(1, 50)); end
                default: ;
            endcase
            run_op(f, a, b, 5'($urandom_range(0, 31)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
